// File: rtl/pp_mult_pkg.sv
// Shared types for the shift-add multiplier controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pp_mult_pkg;

   // Controller states. The 3-bit encoding leaves three spare codes, and the
   // FSM sends each of them back to IDLE.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ADD   = 3'd2,
      ST_SHIFT = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Width of a counter that must be able to hold the value data_width itself.
   function automatic int cnt_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/pp_bit_counter.sv
// Clear/increment iteration counter with a look-ahead terminal flag.
// Latency: count updates one cycle after i_clr/i_inc; o_last is combinational from the count.
// Backpressure: none; the counter holds whenever i_inc is low.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset (count cleared)
//   i_clr         synchronous clear to 0 (has priority over i_inc)
//   i_inc         increment by one
//   o_count       current count
//   o_last        high when the next increment reaches MAX_COUNT
module pp_bit_counter #(
   parameter int MAX_COUNT = 8,
   parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count,
   output logic             o_last
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;
   // Look-ahead flag: lets the owner pick its next state in the same cycle
   // as the final increment rather than one cycle later.
   assign o_last  = (r_count == CNT_W'(MAX_COUNT - 1));

endmodule

// File: rtl/pp_mult_ctrl.sv
// Sequencer for the shift-add multiplier: LOAD, then one ADD/SHIFT pair per multiplier bit (LSB first), then DONE.
// Latency: done is asserted 2*DATA_WIDTH+2 cycles after start is accepted; ready returns one cycle later.
// Backpressure: start is taken only while ready=1 and ignored otherwise; abort cancels a job in any busy state.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   start          multiply request, accepted only in IDLE
//   in_multiplier  operand, sampled when start is accepted
//   abort          synchronous cancel back to IDLE (no done)
//   ready          IDLE indicator
//   en_load        LOAD strobe (clear accumulator / load multiplicand)
//   en_PPReg       ADD strobe (capture adder result)
//   add_en         current multiplier LSB during ADD, else 0
//   shift_en       SHIFT strobe
//   done           one-cycle completion pulse
//   bit_count      number of multiplier bits consumed
module pp_mult_ctrl
   import pp_mult_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                start,
   input  logic [DATA_WIDTH-1:0]               in_multiplier,
   input  logic                                abort,
   output logic                                ready,
   output logic                                en_load,
   output logic                                en_PPReg,
   output logic                                add_en,
   output logic                                shift_en,
   output logic                                done,
   output logic [cnt_width(DATA_WIDTH)-1:0]    bit_count
);

   localparam int CNT_W = cnt_width(DATA_WIDTH);

   state_t                r_state;
   state_t                w_next;
   logic [DATA_WIDTH-1:0] r_mreg;
   logic                  w_accept;
   logic                  w_step;
   logic                  w_last;

   // abort wins over a simultaneous start in IDLE.
   assign w_accept = (r_state == ST_IDLE) && start && !abort;
   // An aborted SHIFT leaves mreg and bit_count untouched.
   assign w_step   = (r_state == ST_SHIFT) && !abort;

   pp_bit_counter #(
      .MAX_COUNT (DATA_WIDTH),
      .CNT_W     (CNT_W)
   ) u_bit_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_accept),
      .i_inc   (w_step),
      .o_count (bit_count),
      .o_last  (w_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mreg <= '0;
      end else if (w_accept) begin
         r_mreg <= in_multiplier;
      end else if (w_step) begin
         r_mreg <= r_mreg >> 1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_next = ST_LOAD;
         ST_LOAD:  w_next = abort ? ST_IDLE : ST_ADD;
         ST_ADD:   w_next = abort ? ST_IDLE : ST_SHIFT;
         ST_SHIFT: begin
            if (abort) begin
               w_next = ST_IDLE;
            end else if (w_last) begin
               w_next = ST_DONE;
            end else begin
               w_next = ST_ADD;
            end
         end
         // DONE completes regardless of abort.
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Every output is a decode of registered state, so none follows an input
   // combinationally.
   assign ready    = (r_state == ST_IDLE);
   assign en_load  = (r_state == ST_LOAD);
   assign en_PPReg = (r_state == ST_ADD);
   assign add_en   = (r_state == ST_ADD) && r_mreg[0];
   assign shift_en = (r_state == ST_SHIFT);
   assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_pp_mult_ctrl.sv
// Self-checking bench for pp_mult_ctrl: a per-cycle timeline model, directed vector table, hand-written corner sequences and random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_pp_mult_ctrl;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          abort;
   logic [W-1:0]  in_mult;
   logic          ready, en_load, en_PPReg, add_en, shift_en, done;
   logic [CW-1:0] bit_count;

   int n_tests = 0;
   int n_fail  = 0;

   pp_mult_ctrl #(.DATA_WIDTH(W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .in_multiplier (in_mult),
      .abort         (abort),
      .ready         (ready),
      .en_load       (en_load),
      .en_PPReg      (en_PPReg),
      .add_en        (add_en),
      .shift_en      (shift_en),
      .done          (done),
      .bit_count     (bit_count)
   );

   always #5 clk = ~clk;

   // Reference model: m_t is the number of cycles elapsed since the job was
   // accepted (0 = idle). The output pattern is a pure function of m_t.
   int           m_t;
   logic [W-1:0] m_op;
   int           m_cnt;

   function automatic logic [5+CW:0] model_exp();
      logic r, l, p, a, s, d;
      r = 1'b0; l = 1'b0; p = 1'b0; a = 1'b0; s = 1'b0; d = 1'b0;
      if (m_t == 0)                r = 1'b1;
      else if (m_t == 1)           l = 1'b1;
      else if (m_t == 2 * W + 2)   d = 1'b1;
      else if ((m_t % 2) == 0) begin
         p = 1'b1;
         a = m_op[(m_t - 2) / 2];
      end else                     s = 1'b1;
      return {r, l, p, a, s, d, CW'(m_cnt)};
   endfunction

   task automatic model_reset();
      m_t = 0; m_op = '0; m_cnt = 0;
   endtask

   task automatic model_step();
      if (!reset_n) begin
         model_reset();
      end else if (m_t == 0) begin
         if (start && !abort) begin
            m_t = 1; m_op = in_mult; m_cnt = 0;
         end
      end else if (m_t == 2 * W + 2) begin
         m_t = 0;
      end else if (abort) begin
         m_t = 0;
      end else begin
         if (m_t >= 3 && (m_t % 2) == 1) m_cnt = (m_t - 3) / 2 + 1;
         m_t++;
      end
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [5+CW:0] dut_vec();
      return {ready, en_load, en_PPReg, add_en, shift_en, done, bit_count};
   endfunction

   // One clock: the model advances on the inputs that the DUT saw at the edge,
   // and both are compared 1 ns later.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check("cycle_model", dut_vec(), model_exp());
      check("strobe_excl", ($countones({en_load, en_PPReg, shift_en, done}) > 1), 0);
   endtask

   typedef struct {
      logic [W-1:0] op;
      int           abort_shift;   // abort during this SHIFT number (0 = none)
      int           ign_add;       // pulse start with 8'hFF during this ADD number (0 = none)
      logic [W-1:0] exp_pat;       // add_en seen in ADD k stored at bit k
      int           exp_adds;
      int           exp_shifts;
      int           exp_done_n;    // cycle of done relative to the start edge (0 = none)
      int           exp_dones;
      int           exp_ready_n;
      int           exp_cnt;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input vec_t v);
      logic [W-1:0] pat;
      int adds, shifts, dones, done_n, ready_n, load_n, n;
      bit fin;
      pat = '0; adds = 0; shifts = 0; dones = 0; done_n = 0; ready_n = 0; load_n = 0;
      fin = 1'b0;
      start = 1'b1; in_mult = v.op;
      cyc();
      start = 1'b0;
      n = 1;
      while (!fin && n <= 40) begin
         if (en_load) load_n = n;
         if (en_PPReg) begin
            if (adds < W) pat[adds] = add_en;
            adds++;
            if (adds == v.ign_add) begin
               start = 1'b1; in_mult = 8'hFF;
            end
         end
         if (shift_en) begin
            shifts++;
            if (shifts == v.abort_shift) abort = 1'b1;
         end
         if (done) begin
            dones++; done_n = n;
         end
         if (ready) begin
            ready_n = n; fin = 1'b1;
         end else begin
            cyc();
            start = 1'b0; abort = 1'b0; in_mult = v.op;
            n++;
         end
      end
      check("vec_timeout", fin, 1);
      check("vec_load_cycle", load_n, 1);
      check("vec_add_pattern", pat, v.exp_pat);
      check("vec_add_pulses", adds, v.exp_adds);
      check("vec_shift_pulses", shifts, v.exp_shifts);
      check("vec_done_cycle", done_n, v.exp_done_n);
      check("vec_done_count", dones, v.exp_dones);
      check("vec_ready_cycle", ready_n, v.exp_ready_n);
      check("vec_bit_count", bit_count, v.exp_cnt);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int loads[$];
      int dones;
      bit drained;

      vecs[0] = '{8'hA5, 0, 0, 8'hA5, 8, 8, 18, 1, 19, 8};
      vecs[1] = '{8'h00, 0, 0, 8'h00, 8, 8, 18, 1, 19, 8};
      vecs[2] = '{8'h01, 0, 2, 8'h01, 8, 8, 18, 1, 19, 8};
      vecs[3] = '{8'hFF, 5, 0, 8'h1F, 5, 5, 0,  0, 12, 4};
      vecs[4] = '{8'h03, 0, 0, 8'h03, 8, 8, 18, 1, 19, 8};
      vecs[5] = '{8'h80, 0, 0, 8'h80, 8, 8, 18, 1, 19, 8};

      // Reset state.
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; in_mult = '0;
      model_reset();
      #12;
      check("reset_outputs", dut_vec(), {6'b100000, CW'(0)});
      cyc();
      reset_n = 1'b1;
      cyc();

      // Directed vector table.
      foreach (vecs[i]) run_vec(vecs[i]);

      // abort together with start in IDLE drops the start.
      start = 1'b1; abort = 1'b1; in_mult = 8'hFF;
      cyc();
      start = 1'b0; abort = 1'b0;
      check("abort_start_ready", ready, 1);
      check("abort_start_noload", en_load, 0);
      cyc();
      check("abort_start_idle", ready, 1);

      // Reset asserted during the third ADD.
      start = 1'b1; in_mult = 8'hA5;
      cyc();
      start = 1'b0;
      repeat (5) cyc();
      check("rst_mid_in_add", {en_PPReg, bit_count}, {1'b1, CW'(2)});
      reset_n = 1'b0;
      #1;
      model_reset();
      check("rst_mid_immediate", dut_vec(), {6'b100000, CW'(0)});
      cyc();
      reset_n = 1'b1;
      cyc();
      check("rst_mid_after", {ready, bit_count}, {1'b1, CW'(0)});

      // Back-to-back: start held high.
      start = 1'b1; in_mult = 8'h80;
      dones = 0;
      for (int n = 1; n <= 45; n++) begin
         cyc();
         if (en_load) loads.push_back(n);
         if (done) dones++;
      end
      start = 1'b0;
      check("b2b_load_count", loads.size(), 3);
      if (loads.size() >= 2) check("b2b_load_spacing", loads[1] - loads[0], 19);
      check("b2b_done_count", dones, 2);
      drained = 1'b0;
      for (int i = 0; i < 40 && !drained; i++) begin
         if (ready) drained = 1'b1;
         else cyc();
      end
      check("b2b_drain", drained, 1);

      // Random traffic against the model, with occasional async resets.
      for (int i = 0; i < 3000; i++) begin
         reset_n = 1'b1;
         start   = ($urandom_range(0, 3) == 0);
         abort   = ($urandom_range(0, 29) == 0);
         in_mult = W'($urandom);
         if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
         cyc();
      end
      reset_n = 1'b1; start = 1'b0; abort = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pp_mult_ctrl.md
# pp_mult_ctrl

Sequencing controller for the shift-add multiplier datapath. Accepts a multiplier operand on a start/ready handshake and walks it LSB-first, one bit per add/shift pair. For each bit it drives the accumulator clear, the partial-product register enable (`en_PPReg`), the conditional-add select and the shift strobe. When all `DATA_WIDTH` bits are consumed it emits a one-cycle `done`. It sits between the top-level multiplier wrapper and the adder / partial-product register pair.

## Interface
- `DATA_WIDTH`, 8, operand width; number of add/shift iterations.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; accepted only when `ready`=1.
- `in_multiplier`  in  DATA_WIDTH  multiplier operand; sampled in the cycle `start` is accepted.
- `abort`  in  1  synchronous cancel; returns to IDLE without `done`.
- `ready`  out  1  high in IDLE only.
- `en_load`  out  1  clear the accumulator / load the multiplicand; LOAD state only.
- `en_PPReg`  out  1  capture the adder result into the partial-product register; ADD state only.
- `add_en`  out  1  select adder versus pass-through; equals current multiplier LSB during ADD, 0 otherwise.
- `shift_en`  out  1  shift the accumulator / partial product right; SHIFT state only.
- `done`  out  1  one-cycle completion pulse.
- `bit_count`  out  $clog2(DATA_WIDTH+1)  number of bits already consumed.

## Operation
- States:
  - IDLE: `ready`=1. Transitions to LOAD when `start`=1. The operand is captured into the internal shift register `mreg`, and `bit_count` is set to 0.
  - LOAD: `en_load`=1. Always transitions to ADD.
  - ADD: `en_PPReg`=1 and `add_en`=`mreg[0]`. Always transitions to SHIFT.
  - SHIFT: `shift_en`=1. Updates `mreg` to `mreg`>>1 (zero fill) and increments `bit_count`. If the incremented `bit_count` equals `DATA_WIDTH`, transitions to DONE; otherwise transitions to ADD.
  - DONE: `done`=1. Always transitions to IDLE.
- `start` while not IDLE: ignored. The operand is not resampled and no queueing occurs.
- `abort` in any non-IDLE state: next state is IDLE. No `done` is issued, and `mreg` and `bit_count` hold their values until the next accepted start.
- `abort` in IDLE: no effect.
- `abort` together with `start` in IDLE: `abort` wins and the start is dropped.
- `abort` during DONE: `done` still asserts in that cycle, then the block goes to IDLE (same path as normal completion).
- Output strobes are mutually exclusive: at most one of `en_load`, `en_PPReg`, `shift_en`, `done` is high in any cycle.
- All outputs are decoded from registered state, so they are glitch-free. There are no combinational paths from inputs to outputs.
- A multiplier value of 0 still runs the full `DATA_WIDTH` iterations, with `add_en` held at 0 throughout. There is no early exit.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - State goes to IDLE.
  - `mreg` and `bit_count` are cleared to 0.
  - `ready`=1; `en_load`, `en_PPReg`, `add_en`, `shift_en` and `done` are all 0.
- Reset asserted mid-operation aborts immediately. The first cycle after release is IDLE.
- Start accepted at edge T gives the following sequence:
  - LOAD in cycle T+1.
  - ADD/SHIFT pairs for bit k (k = 0..DATA_WIDTH-1) in cycles T+2+2k and T+3+2k.
  - `done` in cycle T+2·DATA_WIDTH+2 (T+18 for width 8).
  - `ready` returns in cycle T+2·DATA_WIDTH+3.
- Throughput: one multiply per 2·DATA_WIDTH+3 cycles. `start` held continuously re-triggers on the first IDLE cycle.

## Structure
- Shared package `pp_mult_pkg`:
  - State enum (IDLE, LOAD, ADD, SHIFT, DONE), 3-bit encoding.
  - Count-width function `$clog2(DATA_WIDTH+1)`.
- Sub-module `pp_bit_counter`: a parameterised clear/increment counter with a terminal-count flag, reused by other iterative blocks. The FSM and `mreg` stay in the top level.

## Test plan
- Reset mid-run: assert `reset_n`=0 during the third ADD -> all strobes 0 and `ready`=1 immediately; after release, IDLE with `bit_count`=0.
- Pattern check: `DATA_WIDTH`=8, `in_multiplier`=8'hA5, `start` in cycle 0 -> LOAD in cycle 1. `add_en` in the ADD cycles reads 1,0,1,0,0,1,0,1. `done` in cycle 18 and `ready` in cycle 19.
- Zero operand: `in_multiplier`=0 -> `add_en` never high, exactly 8 `en_PPReg` pulses and 8 `shift_en` pulses, `done` in cycle 18.
- Ignored start: pulse `start` with 8'hFF during an ADD of an 8'h01 job -> the `add_en` sequence remains 1,0,0,0,0,0,0,0 and only one `done` is issued.
- Abort: `abort` in the 5th SHIFT -> IDLE next cycle, no `done`. A following start with 8'h03 then runs normally with `add_en` = 1,1,0,0,0,0,0,0.
- Back-to-back: hold `start`=1 with 8'h80 -> the second LOAD occurs exactly 19 cycles after the first, `done` pulses once per job, and the strobes are never simultaneous.
